// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order reorder buffer sitting between dispatch, the CDB and the
//   architectural register file. Dispatch allocates ROB ids in program order,
//   the CDB marks entries complete, and up to COMMIT_WIDTH completed entries
//   retire per cycle from the head. Committing a mispredicted branch raises a
//   one-cycle branch_mispredict pulse and empties the buffer.
//
//   Optional feature macro: ROB_CDB_BYPASS_EN
//     defined   - a same-cycle CDB write to an entry counts as done for
//                 commit; data/mispredict come from the CDB port (0-cycle).
//     undefined - commit sees only registered done bits (1-cycle latency).
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   alloc_valid/rd_addr  per-lane allocation request (contiguous from lane 0)
//   alloc_ready          at least DISPATCH_WIDTH entries free (registered count)
//   alloc_ptr            ROB id given to lane 0; lane i gets alloc_ptr+i
//   cdb_*                completion ports: id, result, mispredict flag
//   wb_*                 per-lane commit writeback (ready, rd, data, id)
//   branch_mispredict    flush pulse on commit of a mispredicted entry
//   occupancy            number of valid entries
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int DEPTH_BITS     = 4,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int CDB_PORTS      = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [DISPATCH_WIDTH-1:0]                alloc_valid,
  input  logic [DISPATCH_WIDTH-1:0][4:0]           alloc_rd_addr,
  output logic                                     alloc_ready,
  output logic [DEPTH_BITS-1:0]                    alloc_ptr,
  input  logic [CDB_PORTS-1:0]                     cdb_valid,
  input  logic [CDB_PORTS-1:0][DEPTH_BITS-1:0]     cdb_rob_id,
  input  logic [CDB_PORTS-1:0][31:0]               cdb_data,
  input  logic [CDB_PORTS-1:0]                     cdb_mispredict,
  output logic [COMMIT_WIDTH-1:0]                  wb_ready,
  output logic [COMMIT_WIDTH-1:0][4:0]             wb_rd_addr,
  output logic [COMMIT_WIDTH-1:0][31:0]            wb_rd_data,
  output logic [COMMIT_WIDTH-1:0][DEPTH_BITS-1:0]  wb_rob_id,
  output logic                                     branch_mispredict,
  output logic [DEPTH_BITS:0]                      occupancy
);

  localparam int DEPTH  = 1 << DEPTH_BITS;
  localparam int CW     = DEPTH_BITS + 1;
  localparam int DATA_W = 32;

  // Entry storage: valid/done are control and get reset; payload does not.
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic              done_q  [DEPTH];
  logic              done_d  [DEPTH];
  logic              misp_q  [DEPTH];
  logic              misp_d  [DEPTH];
  logic [4:0]        rd_q    [DEPTH];
  logic [4:0]        rd_d    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];

  logic [DEPTH_BITS-1:0] head_q, head_d;
  logic [DEPTH_BITS-1:0] tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  flush;
  logic [DEPTH_BITS-1:0] flush_ptr;
  logic [CW-1:0]         n_commit;
  logic [CW-1:0]         n_alloc;
  logic                  space_ok;

  // Free-space test uses the registered count only; commits in the same
  // cycle are deliberately not credited.
  assign space_ok = (int'(count_q) <= (DEPTH - DISPATCH_WIDTH));

  assign alloc_ready       = rst | space_ok;
  assign alloc_ptr         = rst ? '0 : tail_q;
  assign occupancy         = rst ? '0 : count_q;
  assign branch_mispredict = flush;

  // Commit selection: consecutive valid+done entries from head; a committing
  // mispredicted entry ends the run and requests a flush.
  always_comb begin
    logic                  run;
    logic [DEPTH_BITS-1:0] idx;
    logic                  done_eff;
    logic                  misp_eff;
    logic [DATA_W-1:0]     data_eff;
    wb_ready   = '0;
    wb_rd_addr = '0;
    wb_rd_data = '0;
    wb_rob_id  = '0;
    flush      = 1'b0;
    flush_ptr  = head_q;
    n_commit   = '0;
    run        = ~rst;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      idx      = head_q + DEPTH_BITS'(k);
      done_eff = done_q[idx];
      misp_eff = misp_q[idx];
      data_eff = data_q[idx];
`ifdef ROB_CDB_BYPASS_EN
      // Later ports override earlier ones, matching the register write.
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_valid[p] && (cdb_rob_id[p] == idx)) begin
          done_eff = 1'b1;
          misp_eff = cdb_mispredict[p];
          data_eff = cdb_data[p];
        end
      end
`endif
      wb_rob_id[k]  = idx;
      wb_rd_addr[k] = rd_q[idx];
      wb_rd_data[k] = data_eff;
      if (run && valid_q[idx] && done_eff) begin
        wb_ready[k] = 1'b1;
        n_commit    = n_commit + CW'(1);
        if (misp_eff) begin
          flush     = 1'b1;
          flush_ptr = idx + DEPTH_BITS'(1);
          run       = 1'b0;
        end
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next state: CDB capture, commit release, allocation, then flush override.
  always_comb begin
    logic                  run_a;
    logic [DEPTH_BITS-1:0] aidx;
    valid_d = valid_q;
    done_d  = done_q;
    misp_d  = misp_q;
    rd_d    = rd_q;
    data_d  = data_q;
    n_alloc = '0;
    run_a   = space_ok & ~flush;

    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && valid_q[cdb_rob_id[p]]) begin
        done_d[cdb_rob_id[p]] = 1'b1;
        misp_d[cdb_rob_id[p]] = cdb_mispredict[p];
        data_d[cdb_rob_id[p]] = cdb_data[p];
      end
    end

    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (wb_ready[k]) begin
        valid_d[wb_rob_id[k]] = 1'b0;
      end
    end

    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      aidx = tail_q + DEPTH_BITS'(i);
      if (run_a && alloc_valid[i]) begin
        valid_d[aidx] = 1'b1;
        done_d[aidx]  = 1'b0;
        misp_d[aidx]  = 1'b0;
        rd_d[aidx]    = alloc_rd_addr[i];
        n_alloc       = n_alloc + CW'(1);
      end else begin
        run_a = 1'b0;
      end
    end

    head_d  = head_q + n_commit[DEPTH_BITS-1:0];
    tail_d  = tail_q + n_alloc[DEPTH_BITS-1:0];
    count_d = count_q + n_alloc - n_commit;

    if (flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        valid_d[e] = 1'b0;
      end
      head_d  = flush_ptr;
      tail_d  = flush_ptr;
      count_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e] <= 1'b0;
        done_q[e]  <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload registers
  always_ff @(posedge clk) begin
    misp_q <= misp_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       alloc_valid;
  logic [1:0][4:0]  alloc_rd_addr;
  logic             alloc_ready;
  logic [3:0]       alloc_ptr;
  logic [1:0]       cdb_valid;
  logic [1:0][3:0]  cdb_rob_id;
  logic [1:0][31:0] cdb_data;
  logic [1:0]       cdb_mispredict;
  logic [1:0]       wb_ready;
  logic [1:0][4:0]  wb_rd_addr;
  logic [1:0][31:0] wb_rd_data;
  logic [1:0][3:0]  wb_rob_id;
  logic             branch_mispredict;
  logic [4:0]       occupancy;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd_addr(alloc_rd_addr),
    .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_data(cdb_data), .cdb_mispredict(cdb_mispredict),
    .wb_ready(wb_ready), .wb_rd_addr(wb_rd_addr),
    .wb_rd_data(wb_rd_data), .wb_rob_id(wb_rob_id),
    .branch_mispredict(branch_mispredict), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          sb_q[$];
  logic [4:0]  exp_rd   [16];
  logic [31:0] exp_data [16];
  int          tb_tail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consume the current inputs at the next edge, then idle them.
  task automatic cyc();
    @(posedge clk);
    #1;
    alloc_valid    = '0;
    cdb_valid      = '0;
    cdb_mispredict = '0;
  endtask

  task automatic do_alloc(input int n, input logic [4:0] r0, input logic [4:0] r1,
                          input bit accept);
    alloc_valid      = (n >= 2) ? 2'b11 : 2'b01;
    alloc_rd_addr[0] = r0;
    alloc_rd_addr[1] = r1;
    if (accept) begin
      for (int i = 0; i < n; i++) begin
        exp_rd[(tb_tail + i) % 16] = (i == 0) ? r0 : r1;
        sb_q.push_back((tb_tail + i) % 16);
      end
      tb_tail = (tb_tail + n) % 16;
    end
  endtask

  task automatic do_cdb(input int port, input int id, input logic [31:0] d, input bit m);
    cdb_valid[port]      = 1'b1;
    cdb_rob_id[port]     = 4'(id);
    cdb_data[port]       = d;
    cdb_mispredict[port] = m;
    exp_data[id]         = d;
  endtask

  // Scoreboard: every commit lane pops the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (wb_ready[k]) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_commit", 64'(wb_rob_id[k]), 64'hFFFF);
          end else begin
            int id;
            id = sb_q.pop_front();
            chk("wb_rob_id", 64'(wb_rob_id[k]), 64'(id));
            chk("wb_rd_addr", 64'(wb_rd_addr[k]), 64'(exp_rd[id]));
            chk("wb_rd_data", 64'(wb_rd_data[k]), 64'(exp_data[id]));
          end
        end
      end
      if (branch_mispredict) sb_q.delete();
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    alloc_valid = '0; alloc_rd_addr = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_data = '0; cdb_mispredict = '0;
    tb_tail = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_ptr", 64'(alloc_ptr), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_wb_ready", 64'(wb_ready), 64'd0);
    chk("rst_mispredict", 64'(branch_mispredict), 64'd0);
    rst = 1'b0;
    cyc();

    // Basic: two lanes, id1 completes before id0
    do_alloc(2, 5'd5, 5'd6, 1'b1);
    cyc();
    chk("t1_alloc_ptr", 64'(alloc_ptr), 64'd2);
    chk("t1_occupancy", 64'(occupancy), 64'd2);
    do_cdb(0, 1, 32'hBB, 1'b0);
    #1 chk("t1_wb_id1_only", 64'(wb_ready), 64'd0);
    cyc();
    do_cdb(0, 0, 32'hAA, 1'b0);
    #1 chk("t1_wb_same", 64'(wb_ready), BYP ? 64'd3 : 64'd0);
    cyc();
    chk("t1_wb_next", 64'(wb_ready), BYP ? 64'd0 : 64'd3);
    if (!BYP) cyc();
    chk("t1_occupancy_end", 64'(occupancy), 64'd0);

    // Out-of-order completion with idle gap
    do_alloc(2, 5'd7, 5'd8, 1'b1);
    cyc();
    do_cdb(1, 3, 32'h33, 1'b0);
    cyc();
    chk("t2_wait0", 64'(wb_ready), 64'd0);
    cyc();
    chk("t2_wait1", 64'(wb_ready), 64'd0);
    do_cdb(0, 2, 32'h22, 1'b0);
    #1 chk("t2_wb_same", 64'(wb_ready), BYP ? 64'd3 : 64'd0);
    cyc();
    chk("t2_wb_next", 64'(wb_ready), BYP ? 64'd0 : 64'd3);
    if (!BYP) cyc();
    chk("t2_occupancy", 64'(occupancy), 64'd0);

    // Both CDB ports hit the same id: higher port's data wins
    do_alloc(1, 5'd9, 5'd0, 1'b1);
    cyc();
    do_cdb(0, 4, 32'h111, 1'b0);
    do_cdb(1, 4, 32'h222, 1'b0);
    cyc();
    if (!BYP) cyc();
    chk("t3_occupancy", 64'(occupancy), 64'd0);

    // Fill to 15 entries
    for (int c = 0; c < 7; c++) begin
      do_alloc(2, 5'((tb_tail * 3 + 1) % 32), 5'((tb_tail * 3 + 4) % 32), 1'b1);
      cyc();
    end
    chk("fill14_occupancy", 64'(occupancy), 64'd14);
    chk("fill14_ready", 64'(alloc_ready), 64'd1);
    do_alloc(1, 5'd17, 5'd0, 1'b1);
    cyc();
    chk("fill15_occupancy", 64'(occupancy), 64'd15);
    chk("fill15_ready", 64'(alloc_ready), 64'd0);
    chk("fill15_ptr", 64'(alloc_ptr), 64'd4);
    do_alloc(2, 5'd20, 5'd21, 1'b0);
    cyc();
    chk("full_ignored_ptr", 64'(alloc_ptr), 64'd4);
    chk("full_ignored_occ", 64'(occupancy), 64'd15);
    do_cdb(0, 5, 32'h5555, 1'b0);
    if (!BYP) cyc();
    #1 chk("full_commit_one", 64'(wb_ready), 64'd1);
    chk("full_no_credit", 64'(alloc_ready), 64'd0);
    cyc();
    chk("after_commit_occ", 64'(occupancy), 64'd14);
    chk("after_commit_ready", 64'(alloc_ready), 64'd1);

    // Drain ids 6..14 so that head sits at 15
    for (int id = 6; id <= 14; id++) begin
      do_cdb(0, id, 32'h1000 + 32'(id), 1'b0);
      cyc();
    end
    cyc();
    cyc();
    chk("drain_occ", 64'(occupancy), 64'd5);
    chk("drain_ptr", 64'(alloc_ptr), 64'd4);

    // Wrap: commit ids 15 and 0 together
    do_cdb(0, 0, 32'h0A0A, 1'b0);
    cyc();
    chk("wrap_wait", 64'(wb_ready), 64'd0);
    do_cdb(1, 15, 32'hF0F0, 1'b0);
    if (!BYP) cyc();
    #1 chk("wrap_wb", 64'(wb_ready), 64'd3);
    chk("wrap_id0", 64'(wb_rob_id[0]), 64'd15);
    chk("wrap_id1", 64'(wb_rob_id[1]), 64'd0);
    cyc();
    chk("wrap_occ", 64'(occupancy), 64'd3);

    // Mispredict on id1 with ids 2,3 done and a same-cycle allocation
    do_cdb(0, 2, 32'h2222, 1'b0);
    do_cdb(1, 3, 32'h3333, 1'b0);
    cyc();
    chk("misp_wait", 64'(wb_ready), 64'd0);
    do_cdb(0, 1, 32'h1111, 1'b1);
    if (!BYP) cyc();
    do_alloc(2, 5'd11, 5'd12, 1'b0);
    #1 chk("misp_wb", 64'(wb_ready), 64'd1);
    chk("misp_pulse", 64'(branch_mispredict), 64'd1);
    cyc();
    tb_tail = 2;
    chk("misp_pulse_end", 64'(branch_mispredict), 64'd0);
    chk("misp_occ", 64'(occupancy), 64'd0);
    chk("misp_ptr", 64'(alloc_ptr), 64'd2);
    chk("misp_wb_after", 64'(wb_ready), 64'd0);

    // Normal operation resumes after the flush
    do_alloc(2, 5'd9, 5'd10, 1'b1);
    cyc();
    do_cdb(0, 2, 32'hD2, 1'b0);
    do_cdb(1, 3, 32'hD3, 1'b0);
    cyc();
    if (!BYP) cyc();
    chk("post_flush_occ", 64'(occupancy), 64'd0);
    chk("post_flush_ptr", 64'(alloc_ptr), 64'd4);

    // Reset mid-operation discards entries
    do_alloc(2, 5'd1, 5'd2, 1'b0);
    cyc();
    chk("midrst_pre_occ", 64'(occupancy), 64'd2);
    rst = 1'b1;
    cyc();
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_ptr", 64'(alloc_ptr), 64'd0);
    chk("midrst_ready", 64'(alloc_ready), 64'd1);
    chk("midrst_wb", 64'(wb_ready), 64'd0);
    rst = 1'b0;
    tb_tail = 0;
    cyc();
    chk("postrst_occ", 64'(occupancy), 64'd0);
    do_alloc(1, 5'd0, 5'd0, 1'b1);
    cyc();
    do_cdb(0, 0, 32'hCAFE, 1'b0);
    cyc();
    if (!BYP) cyc();
    chk("postrst_commit_occ", 64'(occupancy), 64'd0);
    cyc();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between dispatch, the CDB and the architectural regfile.
- Allocates ROB ids to decoded instructions and exposes the allocation pointer that regfile uses for rename tagging.
- Captures completed results from the CDB and retires up to COMMIT_WIDTH instructions per cycle in program order on the commit writeback bus.
- On commit of a mispredicted branch, raises the flush signal and empties itself.

Parameters:
- DEPTH_BITS, 4, log2 of entry count (16 entries); ROB id width.
- DISPATCH_WIDTH, 2, allocation lanes per cycle.
- COMMIT_WIDTH, 2, commit lanes per cycle.
- CDB_PORTS, 2, completion ports per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  [DISPATCH_WIDTH]  lane allocates an entry
- alloc_rd_addr  in  [DISPATCH_WIDTH][5]  destination register per lane
- alloc_ready  out  1  at least DISPATCH_WIDTH entries free
- alloc_ptr  out  DEPTH_BITS  id assigned to lane 0; lane i gets alloc_ptr+i
- cdb_valid  in  [CDB_PORTS]  result valid
- cdb_rob_id  in  [CDB_PORTS][DEPTH_BITS]  completing entry
- cdb_data  in  [CDB_PORTS][32]  result value
- cdb_mispredict  in  [CDB_PORTS]  completing branch was mispredicted
- wb_ready  out  [COMMIT_WIDTH]  lane commits this cycle
- wb_rd_addr  out  [COMMIT_WIDTH][5]  committed destination
- wb_rd_data  out  [COMMIT_WIDTH][32]  committed value
- wb_rob_id  out  [COMMIT_WIDTH][DEPTH_BITS]  committed entry id
- branch_mispredict  out  1  flush pulse
- occupancy  out  DEPTH_BITS+1  valid entry count

Behaviour:
- State:
  - Per entry: valid, done, mispredict, rd_addr[5], data[32].
  - head, tail: DEPTH_BITS, wrap modulo 2^DEPTH_BITS.
  - count: DEPTH_BITS+1.
- Reset: head=tail=count=0; all valid/done cleared. While rst is high: wb_ready=0, branch_mispredict=0, alloc_ready=1, alloc_ptr=0, occupancy=0. Reset mid-operation discards all entries.
- Allocation:
  - alloc_ready = (2^DEPTH_BITS - count) >= DISPATCH_WIDTH, computed from registered count only; same-cycle commits are not credited.
  - alloc_valid must be contiguous from lane 0. Lane i writes entry tail+i: valid=1, done=0, mispredict=0, rd_addr latched.
  - tail advances by the number of allocating lanes.
  - Allocation with alloc_ready=0 is ignored.
  - alloc_ptr = tail, combinational from registers.
- Completion:
  - cdb_valid on a valid entry sets done=1 and latches data and mispredict at the clock edge.
  - CDB on an invalid entry is ignored.
  - Two CDB ports hitting the same id in one cycle is illegal; the higher port wins.
- Commit, combinational from registered state, zero latency:
  - Lane k asserts wb_ready iff entries head..head+k are all valid and done, and no lower lane commits a mispredicted entry.
  - wb_rob_id = head+k. wb_rd_data is passed even when rd_addr=0; regfile filters x0.
  - head advances and count decrements by the number of committing lanes.
- Flush:
  - branch_mispredict=1 in the cycle a committing lane carries mispredict=1. The entry itself commits.
  - At that edge: all valid bits are cleared; head=tail=head+k+1 (k = committing lane index); count=0.
  - Same-cycle allocations and CDB writes are dropped.
  - branch_mispredict is a one-cycle pulse.
- Simultaneous allocation, commit and CDB in one cycle are all legal. Counter update: count += allocated - committed.
- CDB-to-commit latency: 1 cycle minimum (done is registered).
- Wrap-around: ids wrap 15→0; commit lanes straddling the wrap are legal.

Optional Feature:
- Macro ROB_CDB_BYPASS_EN.
- Defined: commit readiness also treats an entry as done if a same-cycle cdb_valid targets it. wb_rd_data and mispredict are taken from the matching CDB port, giving 0-cycle CDB-to-commit latency.
- Undefined: commit considers only registered done bits, giving 1-cycle latency.

Test Plan:
- Reset, allocate lanes 0/1 with rd=5,6 → alloc_ptr 0→2, occupancy 2; CDB id1=0xBB then id0=0xAA → wb_ready=11 with rd 5/6, data AA/BB, ids 0/1 in the cycle after the id0 write; occupancy 0.
- Out-of-order completion: id1 completes first → no commit until id0 completes; then both commit in the same cycle.
- Fill to 15 entries → alloc_ready=0. Attempted allocation is ignored, tail unchanged. One commit brings count to 14 → alloc_ready=1 next cycle.
- Wrap: head=15, tail=1, both done → commits ids 15 and 0; head=1.
- Mispredict: ids 3,4,5 done, id3 mispredict=1, with a same-cycle allocation → only lane 0 commits, branch_mispredict=1 for one cycle; next cycle occupancy 0, head=tail=4, allocation dropped.
- Bypass (macro defined): id0 CDB arrives while at head → wb_ready[0]=1 the same cycle; with the macro undefined, the commit occurs one cycle later.
